pcs_receive: RTL and testbench

PCS_RECEIVE -- requirements
Module: pcs_receive

---
 rtl/pcs_codes.sv | 54 +++++
 rtl/pcs_cg_classify.sv | 33 +++
 rtl/pcs_receive.sv | 176 +++++++++++++++++
 tb/tb_pcs_receive.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_codes.sv
// Shared 1000BASE-X PCS code-group constants, receive state encoding and
// code-group classes. Used by both the receive and transmit PCS.
package pcs_codes;

    // Special code-group octets (valid only together with the K flag)
    localparam logic [7:0] CG_K28_5 = 8'hBC;   // comma
    localparam logic [7:0] CG_SOP   = 8'hFB;   // /S/ start of packet
    localparam logic [7:0] CG_EOP   = 8'hFD;   // /T/ end of packet
    localparam logic [7:0] CG_CEXT  = 8'hF7;   // /R/ carrier extend
    localparam logic [7:0] CG_ERR   = 8'hFE;   // /V/ error propagation

    // Second octet of ordered sets (D code-groups)
    localparam logic [7:0] CG_IDLE1 = 8'hC5;   // /I1/ D5.6
    localparam logic [7:0] CG_IDLE2 = 8'h50;   // /I2/ D16.2
    localparam logic [7:0] CG_CFG1  = 8'hB5;   // /C1/ D21.5
    localparam logic [7:0] CG_CFG2  = 8'h42;   // /C2/ D2.2

    // GMII RXD values generated locally
    localparam logic [7:0] RXD_NONE          = 8'h00;
    localparam logic [7:0] RXD_PREAMBLE      = 8'h55;
    localparam logic [7:0] RXD_FALSE_CARRIER = 8'h0E;
    localparam logic [7:0] RXD_CARRIER_ERR   = 8'h1F;

    typedef enum logic [2:0] {
        ST_LINK_FAILED   = 3'd0,
        ST_WAIT_FOR_K    = 3'd1,
        ST_RX_K          = 3'd2,
        ST_IDLE_D        = 3'd3,
        ST_FALSE_CARRIER = 3'd4,
        ST_RECEIVE       = 3'd5,
        ST_TRI_RRI       = 3'd6
    } rx_state_e;

    typedef enum logic [2:0] {
        CLS_DATA    = 3'd0,    // D code-group, valid
        CLS_COMMA   = 3'd1,    // K28.5
        CLS_SOP     = 3'd2,    // /S/
        CLS_EOP     = 3'd3,    // /T/
        CLS_CEXT    = 3'd4,    // /R/
        CLS_ERR     = 3'd5,    // /V/ or invalid code-group
        CLS_K_OTHER = 3'd6     // any other K code-group
    } cg_class_e;

    // Second octet of an /I/ ordered set
    function automatic logic is_idle_octet(input logic [7:0] cg);
        return (cg == CG_IDLE1) || (cg == CG_IDLE2);
    endfunction

    // Second octet of a /C/ ordered set
    function automatic logic is_cfg_octet(input logic [7:0] cg);
        return (cg == CG_CFG1) || (cg == CG_CFG2);
    endfunction

endpackage

// File: rtl/pcs_cg_classify.sv
// Combinational code-group classifier. An invalid code-group or disparity
// error always classifies as /V/, regardless of the K flag.
module pcs_cg_classify
    import pcs_codes::*;
(
    input  logic [7:0] cg_i,
    input  logic       k_i,
    input  logic       valid_i,
    output cg_class_e  cls_o,
    output logic       idle_o
);

    // Map the octet plus K/valid flags onto a code-group class
    always_comb begin
        cls_o = CLS_DATA;
        if (!valid_i) begin
            cls_o = CLS_ERR;
        end else if (k_i) begin
            case (cg_i)
                CG_K28_5: cls_o = CLS_COMMA;
                CG_SOP:   cls_o = CLS_SOP;
                CG_EOP:   cls_o = CLS_EOP;
                CG_CEXT:  cls_o = CLS_CEXT;
                CG_ERR:   cls_o = CLS_ERR;
                default:  cls_o = CLS_K_OTHER;
            endcase
        end
    end

    // /I/ second octet; /C/ octets deliberately fall through to "other"
    assign idle_o = valid_i && !k_i && is_idle_octet(cg_i);

endmodule

// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive: turns classified code-groups into GMII RXD/RX_DV/
// RX_ER with one GTX_CLK of latency and counts /S/-started frames.
//
// state            | meaning
// -----------------+----------------------------------------------------
// LINK_FAILED      | no code-group alignment; outputs idle
// WAIT_FOR_K       | hunting for a K28.5 comma
// RX_K             | comma seen, expecting second octet of /I/ or /C/
// IDLE_D           | /I/ complete, next comma / /S/ / carrier decides
// FALSE_CARRIER    | carrier without /S/; RXD=0x0E, RX_ER until comma
// RECEIVE          | inside a frame, forwarding data
// TRI_RRI          | after /T/, absorbing /R/ until the next comma
module pcs_receive
    import pcs_codes::*;
(
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic       sync_status,
    input  logic [7:0] rx_cg,
    input  logic       rx_k,
    input  logic       rx_cg_valid,
    output logic [7:0] RXD,
    output logic       RX_DV,
    output logic       RX_ER,
    output logic       receiving,
    output logic [7:0] rx_packets
);

    rx_state_e  state_q, state_d;
    logic [7:0] rxd_q, rxd_d;
    logic       rx_dv_q, rx_dv_d;
    logic       rx_er_q, rx_er_d;
    logic       receiving_q, receiving_d;
    logic [7:0] rx_packets_q, rx_packets_d;

    cg_class_e  cg_cls;
    logic       cg_idle;

    pcs_cg_classify u_classify (
        .cg_i    (rx_cg),
        .k_i     (rx_k),
        .valid_i (rx_cg_valid),
        .cls_o   (cg_cls),
        .idle_o  (cg_idle)
    );

    // Next state and next registered outputs; sync loss overrides all states
    always_comb begin
        state_d      = state_q;
        rxd_d        = RXD_NONE;
        rx_dv_d      = 1'b0;
        rx_er_d      = 1'b0;
        receiving_d  = 1'b0;
        rx_packets_d = rx_packets_q;

        if (!sync_status) begin
            state_d = ST_LINK_FAILED;
            // a frame cut short by sync loss is flagged for one cycle
            rx_er_d = (state_q == ST_RECEIVE);
        end else begin
            case (state_q)
                ST_LINK_FAILED: begin
                    state_d = ST_WAIT_FOR_K;
                end

                ST_WAIT_FOR_K: begin
                    if (cg_cls == CLS_COMMA) begin
                        state_d = ST_RX_K;
                    end
                end

                ST_RX_K: begin
                    // /C/ and anything unexpected both go back to hunting
                    state_d = cg_idle ? ST_IDLE_D : ST_WAIT_FOR_K;
                end

                ST_IDLE_D: begin
                    case (cg_cls)
                        CLS_COMMA: begin
                            state_d = ST_RX_K;
                        end
                        CLS_SOP: begin
                            state_d      = ST_RECEIVE;
                            rxd_d        = RXD_PREAMBLE;
                            rx_dv_d      = 1'b1;
                            receiving_d  = 1'b1;
                            rx_packets_d = rx_packets_q + 8'd1;
                        end
                        default: begin
                            state_d     = ST_FALSE_CARRIER;
                            rxd_d       = RXD_FALSE_CARRIER;
                            rx_er_d     = 1'b1;
                            receiving_d = 1'b1;
                        end
                    endcase
                end

                ST_FALSE_CARRIER: begin
                    if (cg_cls == CLS_COMMA) begin
                        state_d = ST_RX_K;
                    end else begin
                        rxd_d       = RXD_FALSE_CARRIER;
                        rx_er_d     = 1'b1;
                        receiving_d = 1'b1;
                    end
                end

                ST_RECEIVE: begin
                    receiving_d = 1'b1;
                    case (cg_cls)
                        CLS_DATA: begin
                            rxd_d   = rx_cg;
                            rx_dv_d = 1'b1;
                        end
                        CLS_EOP: begin
                            state_d = ST_TRI_RRI;
                        end
                        CLS_COMMA: begin
                            // frame ended without /T/
                            state_d     = ST_RX_K;
                            rx_er_d     = 1'b1;
                            receiving_d = 1'b0;
                        end
                        default: begin
                            rxd_d   = rx_cg;
                            rx_dv_d = 1'b1;
                            rx_er_d = 1'b1;
                        end
                    endcase
                end

                ST_TRI_RRI: begin
                    if (cg_cls == CLS_COMMA) begin
                        state_d = ST_RX_K;
                    end else begin
                        receiving_d = 1'b1;
                        if (cg_cls != CLS_CEXT) begin
                            rxd_d   = RXD_CARRIER_ERR;
                            rx_er_d = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = ST_LINK_FAILED;
                end
            endcase
        end
    end

    // State and output registers; reset clears everything without an RX_ER pulse
    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state_q      <= ST_LINK_FAILED;
            rxd_q        <= RXD_NONE;
            rx_dv_q      <= 1'b0;
            rx_er_q      <= 1'b0;
            receiving_q  <= 1'b0;
            rx_packets_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            rxd_q        <= rxd_d;
            rx_dv_q      <= rx_dv_d;
            rx_er_q      <= rx_er_d;
            receiving_q  <= receiving_d;
            rx_packets_q <= rx_packets_d;
        end
    end

    assign RXD        = rxd_q;
    assign RX_DV      = rx_dv_q;
    assign RX_ER      = rx_er_q;
    assign receiving  = receiving_q;
    assign rx_packets = rx_packets_q;

endmodule

// File: tb/tb_pcs_receive.sv
// Testbench for pcs_receive: directed code-group sequences, a flag-based
// behavioural model checked every cycle, plus literal spot checks.
module tb_pcs_receive;

    logic       GTX_CLK = 1'b0;
    logic       mr_main_reset;
    logic       sync_status;
    logic [7:0] rx_cg;
    logic       rx_k;
    logic       rx_cg_valid;
    logic [7:0] RXD;
    logic       RX_DV;
    logic       RX_ER;
    logic       receiving;
    logic [7:0] rx_packets;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    pcs_receive dut (
        .GTX_CLK       (GTX_CLK),
        .mr_main_reset (mr_main_reset),
        .sync_status   (sync_status),
        .rx_cg         (rx_cg),
        .rx_k          (rx_k),
        .rx_cg_valid   (rx_cg_valid),
        .RXD           (RXD),
        .RX_DV         (RX_DV),
        .RX_ER         (RX_ER),
        .receiving     (receiving),
        .rx_packets    (rx_packets)
    );

    always #5 GTX_CLK = ~GTX_CLK;

    // Model: link/comma/idle/frame/extend/false-carrier flags plus expected outputs
    typedef struct packed {
        logic       link;     // sync seen since last loss/reset
        logic       after_k;  // previous code-group was an accepted comma
        logic       idle;     // comma + /I/ seen, carrier detect armed
        logic       frame;    // inside /S/ .. /T/
        logic       ext;      // after /T/, waiting for comma
        logic       fc;       // false carrier
        logic [7:0] rxd;
        logic       dv;
        logic       er;
        logic       rcv;
        logic [7:0] pkts;
    } mdl_t;

    mdl_t mdl;

    function automatic mdl_t mdl_next(mdl_t m, logic s, logic [7:0] cg, logic k, logic v);
        mdl_t n;
        logic comma, sop, eop, cext, data;
        comma = v && k && (cg == 8'hBC);
        sop   = v && k && (cg == 8'hFB);
        eop   = v && k && (cg == 8'hFD);
        cext  = v && k && (cg == 8'hF7);
        data  = v && !k;
        n = m;
        n.rxd = 8'h00;
        n.dv  = 1'b0;
        n.er  = 1'b0;
        n.rcv = 1'b0;
        if (!s) begin
            n.er = m.frame;
            n.link = 0; n.after_k = 0; n.idle = 0; n.frame = 0; n.ext = 0; n.fc = 0;
        end else if (!m.link) begin
            n.link = 1;
        end else if (m.frame) begin
            if (comma) begin
                n.frame = 0; n.after_k = 1; n.er = 1;
            end else if (eop) begin
                n.frame = 0; n.ext = 1; n.rcv = 1;
            end else begin
                n.rcv = 1; n.dv = 1; n.rxd = cg; n.er = !data;
            end
        end else if (m.ext) begin
            if (comma) begin
                n.ext = 0; n.after_k = 1;
            end else begin
                n.rcv = 1;
                if (!cext) begin
                    n.er = 1; n.rxd = 8'h1F;
                end
            end
        end else if (m.fc) begin
            if (comma) begin
                n.fc = 0; n.after_k = 1;
            end else begin
                n.rcv = 1; n.er = 1; n.rxd = 8'h0E;
            end
        end else if (m.idle) begin
            n.idle = 0;
            if (comma) begin
                n.after_k = 1;
            end else if (sop) begin
                n.frame = 1; n.rxd = 8'h55; n.dv = 1; n.rcv = 1; n.pkts = m.pkts + 8'd1;
            end else begin
                n.fc = 1; n.rcv = 1; n.er = 1; n.rxd = 8'h0E;
            end
        end else if (m.after_k) begin
            n.after_k = 0;
            n.idle = data && ((cg == 8'hC5) || (cg == 8'h50));
        end else begin
            n.after_k = comma;
        end
        return n;
    endfunction

    always @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) mdl <= '0;
        else                mdl <= mdl_next(mdl, sync_status, rx_cg, rx_k, rx_cg_valid);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge GTX_CLK) begin
        if (chk_en) begin
            check("mdl_rxd",        RXD,               mdl.rxd);
            check("mdl_rx_dv",      {7'd0, RX_DV},     {7'd0, mdl.dv});
            check("mdl_rx_er",      {7'd0, RX_ER},     {7'd0, mdl.er});
            check("mdl_receiving",  {7'd0, receiving}, {7'd0, mdl.rcv});
            check("mdl_rx_packets", rx_packets,        mdl.pkts);
        end
    end

    task automatic send(input logic s, input logic [7:0] cg, input logic k, input logic v);
        @(negedge GTX_CLK);
        sync_status = s;
        rx_cg       = cg;
        rx_k        = k;
        rx_cg_valid = v;
        @(posedge GTX_CLK);
        #1;
    endtask

    task automatic comma();  send(1'b1, 8'hBC, 1'b1, 1'b1); endtask
    task automatic idle_d(); send(1'b1, 8'hC5, 1'b0, 1'b1); endtask
    task automatic sop();    send(1'b1, 8'hFB, 1'b1, 1'b1); endtask
    task automatic eop();    send(1'b1, 8'hFD, 1'b1, 1'b1); endtask
    task automatic data(input logic [7:0] d); send(1'b1, d, 1'b0, 1'b1); endtask

    task automatic check_out(input string tag, input logic [7:0] rxd, input logic dv,
                             input logic er, input logic rcv);
        check({tag, "_rxd"},       RXD,               rxd);
        check({tag, "_rx_dv"},     {7'd0, RX_DV},     {7'd0, dv});
        check({tag, "_rx_er"},     {7'd0, RX_ER},     {7'd0, er});
        check({tag, "_receiving"}, {7'd0, receiving}, {7'd0, rcv});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        mr_main_reset = 1'b0;
        sync_status   = 1'b0;
        rx_cg         = 8'h00;
        rx_k          = 1'b0;
        rx_cg_valid   = 1'b1;
        #2;
        check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset_pkts", rx_packets, 8'h00);
        chk_en = 1'b1;
        repeat (2) @(negedge GTX_CLK);
        mr_main_reset = 1'b1;

        // Link up, K28.5 D5.6 repeated
        send(1'b1, 8'h00, 1'b0, 1'b1);
        repeat (4) begin comma(); idle_d(); end
        check_out("idle", 8'h00, 1'b0, 1'b0, 1'b0);
        check("idle_pkts", rx_packets, 8'h00);

        // Good frame
        sop();          check_out("sop", 8'h55, 1'b1, 1'b0, 1'b1);
        data(8'h11);    check_out("d11", 8'h11, 1'b1, 1'b0, 1'b1);
        data(8'h22);    check_out("d22", 8'h22, 1'b1, 1'b0, 1'b1);
        eop();          check_out("eop", 8'h00, 1'b0, 1'b0, 1'b1);
        send(1'b1, 8'hF7, 1'b1, 1'b1); check_out("cext", 8'h00, 1'b0, 1'b0, 1'b1);
        comma();        check_out("end1", 8'h00, 1'b0, 1'b0, 1'b0);
        check("pkts1", rx_packets, 8'h01);

        // Frame with invalid code-group, unexpected K, bad carrier extension
        idle_d();
        sop();
        data(8'hA1);
        send(1'b1, 8'h99, 1'b0, 1'b0); check_out("inval", 8'h99, 1'b1, 1'b1, 1'b1);
        data(8'hA2);                   check_out("after_inval", 8'hA2, 1'b1, 1'b0, 1'b1);
        send(1'b1, 8'h1C, 1'b1, 1'b1); check_out("kother", 8'h1C, 1'b1, 1'b1, 1'b1);
        eop();
        data(8'h44);                   check_out("ext_err", 8'h1F, 1'b0, 1'b1, 1'b1);
        send(1'b1, 8'hF7, 1'b1, 1'b1); check_out("ext_ok", 8'h00, 1'b0, 1'b0, 1'b1);
        comma();
        check("pkts2", rx_packets, 8'h02);

        // False carrier
        idle_d();
        data(8'h33);    check_out("fc1", 8'h0E, 1'b0, 1'b1, 1'b1);
        data(8'h77);    check_out("fc2", 8'h0E, 1'b0, 1'b1, 1'b1);
        comma();        check_out("fc_end", 8'h00, 1'b0, 1'b0, 1'b0);
        check("pkts_fc", rx_packets, 8'h02);

        // Early end on comma
        idle_d();
        sop();
        data(8'h10);
        comma();        check_out("early", 8'h00, 1'b0, 1'b1, 1'b0);
        idle_d();       check_out("early_next", 8'h00, 1'b0, 1'b0, 1'b0);
        check("pkts3", rx_packets, 8'h03);

        // Sync loss mid-frame
        sop();
        data(8'h20);
        send(1'b0, 8'h21, 1'b0, 1'b1); check_out("syncloss", 8'h00, 1'b0, 1'b1, 1'b0);
        send(1'b0, 8'h22, 1'b0, 1'b1); check_out("linkfail", 8'h00, 1'b0, 1'b0, 1'b0);
        check("pkts4", rx_packets, 8'h04);

        // /S/ coinciding with sync loss
        send(1'b1, 8'h00, 1'b0, 1'b1);
        comma();
        idle_d();
        send(1'b0, 8'hFB, 1'b1, 1'b1); check_out("sop_syncloss", 8'h00, 1'b0, 1'b0, 1'b0);
        check("pkts_sop_syncloss", rx_packets, 8'h04);

        // Asynchronous reset mid-frame
        send(1'b1, 8'h00, 1'b0, 1'b1);
        comma();
        idle_d();
        sop();
        data(8'h66);    check_out("pre_rst", 8'h66, 1'b1, 1'b0, 1'b1);
        #2;
        mr_main_reset = 1'b0;
        #1;
        check_out("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        check("async_rst_pkts", rx_packets, 8'h00);
        repeat (2) @(negedge GTX_CLK);
        mr_main_reset = 1'b1;
        sop();          check_out("post_rst1", 8'h00, 1'b0, 1'b0, 1'b0);
        sop();          check_out("post_rst2", 8'h00, 1'b0, 1'b0, 1'b0);

        // 256 frames: counter wraps
        comma();
        idle_d();
        for (int i = 0; i < 256; i++) begin
            sop();
            eop();
            comma();
            idle_d();
            if (i == 254) check("pkts_ff", rx_packets, 8'hFF);
        end
        check("pkts_wrap", rx_packets, 8'h00);

        @(negedge GTX_CLK);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
